// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// port and a load/store data port. At most one transaction is outstanding.
//
// Handshake: a requester raises *_req with stable operands and holds them until
// the matching *_gnt is seen high in a cycle. The grant is combinational.
// Grants only issue in IDLE. Reads complete LATENCY cycles after the grant with
// a one-cycle if_rvalid/d_done pulse. Stores complete one cycle after the
// grant. The next grant can issue the cycle after any completion.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   if_req/if_addr       fetch request; if_gnt, if_rvalid, if_rdata back
//   d_req/d_we/d_addr/   data request (load/store, width in funct3[1:0] form)
//   d_wdata/d_width      d_gnt, d_done, d_rdata back
//   mem_*                memory strobe, write enable, address, data, width
//   mem_rdata            memory read data, valid LATENCY cycles after mem_en
//   busy                 high whenever a transaction is outstanding
//   dbg_state_o          current FSM state encoding
module mem_arbiter #(
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_width,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_IF   = 2'd1,
        BUSY_D_RD = 2'd2,
        BUSY_D_WR = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT   = 3'(LATENCY);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t      state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [3:0]  streak_q, streak_d;
    logic [31:0] if_rdata_q, d_rdata_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [1:0]  mem_width_q;

    logic fetch_turn;
    logic if_gnt_raw, d_gnt_raw, if_cpl_raw, d_rd_cpl_raw, d_wr_cpl_raw;
    logic d_rd_cpl;

    // Fetch wins when data is idle, or when data has starved a waiting fetch
    // for MAX_D_STREAK grants in a row.
    assign fetch_turn = if_req && (!d_req || (streak_q == STREAK_MAX));

    // Next state and raw (pre-reset-gating) grant/completion decisions.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        streak_d     = streak_q;
        if_gnt_raw   = 1'b0;
        d_gnt_raw    = 1'b0;
        if_cpl_raw   = 1'b0;
        d_rd_cpl_raw = 1'b0;
        d_wr_cpl_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_turn) begin
                    if_gnt_raw = 1'b1;
                    lat_d      = LAT_INIT;
                    streak_d   = 4'd0;
                    state_d    = BUSY_IF;
                end else if (d_req) begin
                    d_gnt_raw = 1'b1;
                    // Streak only tracks data grants that made a fetch wait.
                    if (!if_req) begin
                        streak_d = 4'd0;
                    end else if (streak_q < STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                    if (d_we) begin
                        state_d = BUSY_D_WR;
                    end else begin
                        lat_d   = LAT_INIT;
                        state_d = BUSY_D_RD;
                    end
                end
            end
            BUSY_IF: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    if_cpl_raw = 1'b1;
                    state_d    = IDLE;
                end
            end
            BUSY_D_RD: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    d_rd_cpl_raw = 1'b1;
                    state_d      = IDLE;
                end
            end
            BUSY_D_WR: begin
                d_wr_cpl_raw = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output datapath. Everything visible is gated by rst so that reset
    // silences grants and pulses even in the cycle it is first applied.
    always_comb begin
        if_gnt    = if_gnt_raw && !rst;
        d_gnt     = d_gnt_raw && !rst;
        if_rvalid = if_cpl_raw && !rst;
        d_rd_cpl  = d_rd_cpl_raw && !rst;
        d_done    = (d_rd_cpl_raw || d_wr_cpl_raw) && !rst;
        busy      = (state_q != IDLE) && !rst;

        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_width = mem_width_q;
        if (if_gnt) begin
            mem_addr  = if_addr;
            mem_width = 2'b10;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_width = d_width;
        end

        // Read data is forwarded in the completion cycle, then held.
        if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
        d_rdata  = d_rd_cpl ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= 3'd0;
            streak_q    <= 4'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_width_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            streak_q    <= streak_d;
            if_rdata_q  <= if_rdata;
            d_rdata_q   <= d_rdata;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
            mem_width_q <= mem_width;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter. Instance a uses LATENCY=1,
// MAX_D_STREAK=4; instance b uses LATENCY=3, MAX_D_STREAK=2. Both share the
// same stimulus; each test checks the instance it targets.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_width;
    logic [31:0] mem_rdata;

    logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_done, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic [1:0]  a_mem_width, a_dbg_state;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_done, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_mem_width, b_dbg_state;

    int errors;
    int n_checks;

    mem_arbiter #(.LATENCY(1), .MAX_D_STREAK(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_gnt(a_d_gnt), .d_done(a_d_done), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_width(a_mem_width), .mem_rdata(mem_rdata),
        .busy(a_busy), .dbg_state_o(a_dbg_state)
    );

    mem_arbiter #(.LATENCY(3), .MAX_D_STREAK(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_gnt(b_d_gnt), .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_width(b_mem_width), .mem_rdata(mem_rdata),
        .busy(b_busy), .dbg_state_o(b_dbg_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    // Checking helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs
    // are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        drop_reqs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((a_busy || b_busy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_busy", {30'd0, a_busy, b_busy}, 32'd0);
    endtask

    // Vector table for single grant-cycle behaviour on instance a
    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [1:0]  d_width;
        logic        exp_if_gnt;
        logic        exp_d_gnt;
        logic        exp_en;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        chk_wdata;
        logic [1:0]  exp_width;
    } vec_t;

    vec_t vecs[10];
    logic [7:0] exp_q[$];
    int got_n;

    initial begin
        errors   = 0;
        n_checks = 0;
        rst      = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0200;
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h0000_1000;
        d_wdata  = 32'h0;
        d_width  = 2'b10;
        mem_rdata = 32'h0;

        //            ifr  if_addr       dr   we   d_addr        d_wdata       w      ig   dg   en   we   addr          wdata         cw   width
        vecs[0] = '{1'b0, 32'h0000_0111, 1'b0, 1'b1, 32'h0000_0222, 32'h0000_0333, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 2'b00};
        vecs[1] = '{1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0222, 32'h0000_0333, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 1'b0, 2'b10};
        vecs[2] = '{1'b0, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 1'b1, 2'b10};
        vecs[3] = '{1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 2'b00};
        vecs[4] = '{1'b0, 32'h0000_0999, 1'b0, 1'b1, 32'h0000_0888, 32'h0000_0777, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 2'b00};
        vecs[5] = '{1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 1'b1, 2'b01};
        vecs[6] = '{1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 1'b1, 2'b01};
        vecs[7] = '{1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_0001, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_0001, 1'b1, 2'b10};
        vecs[8] = '{1'b1, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_004C, 32'h0000_0002, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 1'b0, 2'b10};
        vecs[9] = '{1'b0, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b1, 2'b10};

        // Reset state, with both requests high while rst is asserted
        next_cycle();
        @(negedge clk);
        chk("rst_a_if_gnt", {31'd0, a_if_gnt}, 32'd0);
        chk("rst_a_d_gnt", {31'd0, a_d_gnt}, 32'd0);
        chk("rst_a_mem_en", {31'd0, a_mem_en}, 32'd0);
        chk("rst_a_mem_we", {31'd0, a_mem_we}, 32'd0);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_a_if_rdata", a_if_rdata, 32'd0);
        chk("rst_a_d_rdata", a_d_rdata, 32'd0);
        chk("rst_a_mem_addr", a_mem_addr, 32'd0);
        chk("rst_a_mem_wdata", a_mem_wdata, 32'd0);
        chk("rst_a_mem_width", {30'd0, a_mem_width}, 32'd0);
        chk("rst_a_state", {30'd0, a_dbg_state}, 32'd0);
        chk("rst_b_gnts", {30'd0, b_if_gnt, b_d_gnt}, 32'd0);
        next_cycle();
        rst = 1'b0;
        drop_reqs();
        wait_idle();

        // Table-driven grant-cycle vectors
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if_req  = vecs[i].if_req;
            if_addr = vecs[i].if_addr;
            d_req   = vecs[i].d_req;
            d_we    = vecs[i].d_we;
            d_addr  = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata;
            d_width = vecs[i].d_width;
            @(negedge clk);
            chk($sformatf("v%0d_if_gnt", i), {31'd0, a_if_gnt}, {31'd0, vecs[i].exp_if_gnt});
            chk($sformatf("v%0d_d_gnt", i), {31'd0, a_d_gnt}, {31'd0, vecs[i].exp_d_gnt});
            chk($sformatf("v%0d_mem_en", i), {31'd0, a_mem_en}, {31'd0, vecs[i].exp_en});
            chk($sformatf("v%0d_mem_we", i), {31'd0, a_mem_we}, {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_mem_addr", i), a_mem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_mem_width", i), {30'd0, a_mem_width}, {30'd0, vecs[i].exp_width});
            if (vecs[i].chk_wdata) begin
                chk($sformatf("v%0d_mem_wdata", i), a_mem_wdata, vecs[i].exp_wdata);
            end
            next_cycle();
            drop_reqs();
            wait_idle();
        end

        // Fetch with LATENCY=1 on instance a
        do_reset();
        wait_idle();
        next_cycle();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0200;
        mem_rdata = 32'h0000_0013;
        @(negedge clk);
        chk("f_if_gnt_T", {31'd0, a_if_gnt}, 32'd1);
        chk("f_mem_addr_T", a_mem_addr, 32'h0000_0200);
        chk("f_busy_T", {31'd0, a_busy}, 32'd0);
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        chk("f_rvalid_T1", {31'd0, a_if_rvalid}, 32'd1);
        chk("f_rdata_T1", a_if_rdata, 32'h0000_0013);
        chk("f_busy_T1", {31'd0, a_busy}, 32'd1);
        chk("f_state_T1", {30'd0, a_dbg_state}, 32'd1);
        next_cycle();
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("f_busy_T2", {31'd0, a_busy}, 32'd0);
        chk("f_rvalid_T2", {31'd0, a_if_rvalid}, 32'd0);
        chk("f_rdata_hold_T2", a_if_rdata, 32'h0000_0013);
        wait_idle();

        // Simultaneous load and fetch on instance a: data first
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_1000;
        d_width = 2'b10;
        @(negedge clk);
        chk("ld_d_gnt_T", {31'd0, a_d_gnt}, 32'd1);
        chk("ld_if_gnt_T", {31'd0, a_if_gnt}, 32'd0);
        chk("ld_mem_addr_T", a_mem_addr, 32'h0000_1000);
        next_cycle();
        d_req     = 1'b0;
        mem_rdata = 32'hABCD_0001;
        @(negedge clk);
        chk("ld_d_done_T1", {31'd0, a_d_done}, 32'd1);
        chk("ld_d_rdata_T1", a_d_rdata, 32'hABCD_0001);
        chk("ld_if_gnt_T1", {31'd0, a_if_gnt}, 32'd0);
        next_cycle();
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("ld_if_gnt_T2", {31'd0, a_if_gnt}, 32'd1);
        chk("ld_mem_addr_T2", a_mem_addr, 32'h0000_0200);
        chk("ld_d_rdata_hold_T2", a_d_rdata, 32'hABCD_0001);
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        chk("ld_if_rvalid_T3", {31'd0, a_if_rvalid}, 32'd1);
        chk("ld_if_rdata_T3", a_if_rdata, 32'h0BAD_F00D);
        chk("ld_d_done_T3", {31'd0, a_d_done}, 32'd0);
        wait_idle();

        // Byte store on instance a with a fetch waiting
        next_cycle();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wdata = 32'hDEAD_BEEF;
        d_width = 2'b00;
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        @(negedge clk);
        chk("st_d_gnt_T", {31'd0, a_d_gnt}, 32'd1);
        chk("st_mem_we_T", {31'd0, a_mem_we}, 32'd1);
        chk("st_mem_width_T", {30'd0, a_mem_width}, 32'd0);
        chk("st_mem_wdata_T", a_mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_addr_T", a_mem_addr, 32'h0000_0040);
        next_cycle();
        d_req     = 1'b0;
        mem_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("st_d_done_T1", {31'd0, a_d_done}, 32'd1);
        chk("st_d_rdata_T1", a_d_rdata, 32'hABCD_0001);
        chk("st_if_gnt_T1", {31'd0, a_if_gnt}, 32'd0);
        chk("st_mem_en_T1", {31'd0, a_mem_en}, 32'd0);
        chk("st_mem_we_T1", {31'd0, a_mem_we}, 32'd0);
        chk("st_mem_addr_hold_T1", a_mem_addr, 32'h0000_0040);
        next_cycle();
        @(negedge clk);
        chk("st_if_gnt_T2", {31'd0, a_if_gnt}, 32'd1);
        chk("st_d_rdata_T2", a_d_rdata, 32'hABCD_0001);
        next_cycle();
        if_req = 1'b0;
        wait_idle();

        // Streak limit on instance b (MAX_D_STREAK=2): D, D, IF, D, D, IF
        do_reset();
        wait_idle();
        exp_q = {};
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h49);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h49);
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h0000_0600;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_2000;
        d_width = 2'b10;
        got_n   = 0;
        for (int c = 0; c < 80 && got_n < 6; c++) begin
            @(negedge clk);
            if (b_if_gnt || b_d_gnt) begin
                chk($sformatf("sk_excl%0d", got_n), {31'd0, b_if_gnt & b_d_gnt}, 32'd0);
                chk($sformatf("sk_grant%0d", got_n), b_d_gnt ? 32'h44 : 32'h49, {24'd0, exp_q.pop_front()});
                got_n++;
            end
        end
        chk("sk_count", got_n, 32'd6);
        next_cycle();
        drop_reqs();
        wait_idle();

        // Reset during an outstanding fetch on instance b (LATENCY=3)
        do_reset();
        wait_idle();
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        @(negedge clk);
        chk("rf_if_gnt_T", {31'd0, b_if_gnt}, 32'd1);
        next_cycle();
        if_req = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        chk("rf_busy_in_rst", {31'd0, b_busy}, 32'd0);
        chk("rf_rvalid_in_rst", {31'd0, b_if_rvalid}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rf_busy_T2", {31'd0, b_busy}, 32'd0);
        chk("rf_rvalid_T2", {31'd0, b_if_rvalid}, 32'd0);
        chk("rf_if_rdata_T2", b_if_rdata, 32'd0);
        chk("rf_mem_addr_T2", b_mem_addr, 32'd0);
        chk("rf_mem_width_T2", {30'd0, b_mem_width}, 32'd0);
        chk("rf_mem_wdata_T2", b_mem_wdata, 32'd0);
        chk("rf_state_T2", {30'd0, b_dbg_state}, 32'd0);
        next_cycle();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0500;
        mem_rdata = 32'h0000_0077;
        @(negedge clk);
        chk("rf_if_gnt_T3", {31'd0, b_if_gnt}, 32'd1);
        chk("rf_mem_addr_T3", b_mem_addr, 32'h0000_0500);
        chk("rf_rvalid_T3", {31'd0, b_if_rvalid}, 32'd0);
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        chk("rf_rvalid_T4", {31'd0, b_if_rvalid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rf_rvalid_T5", {31'd0, b_if_rvalid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rf_rvalid_T6", {31'd0, b_if_rvalid}, 32'd1);
        chk("rf_rdata_T6", b_if_rdata, 32'h0000_0077);
        wait_idle();

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, memory read latency in cycles from grant to read data (legal 1..4).
REQ-002 Parameter MAX_D_STREAK, default 4, maximum consecutive data grants while fetch is pending (legal 1..15).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 if_req  in  1  instruction fetch request, held until if_gnt.
REQ-007 if_addr  in  32  fetch byte address, stable while if_req is high.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  one-cycle pulse: if_rdata valid.
REQ-010 if_rdata  out  32  fetched instruction word.
REQ-011 d_req  in  1  data request, held until d_gnt.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  32  data byte address.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_width  in  2  access width, funct3[1:0] encoding: 00 byte, 01 half, 10 word.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_done  out  1  one-cycle pulse: load data valid or store complete.
REQ-018 d_rdata  out  32  raw load word, unadjusted.
REQ-019 mem_en  out  1  memory access strobe.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_addr  out  32  memory address.
REQ-022 mem_wdata  out  32  memory write data.
REQ-023 mem_width  out  2  memory access width.
REQ-024 mem_rdata  in  32  memory read data, valid LATENCY cycles after mem_en.
REQ-025 busy  out  1  high in any state other than IDLE.

Function
REQ-026 FSM states: IDLE, BUSY_IF, BUSY_D_RD, BUSY_D_WR; one transaction outstanding at most.
REQ-027 Grants are combinational and issue only in IDLE; if_gnt and d_gnt are never high in the same cycle.
REQ-028 Priority: d_req over if_req, except when streak == MAX_D_STREAK and if_req is high, in which case fetch wins.
REQ-029 Grant cycle T: mem_en=1; mem_addr, mem_we, mem_wdata and mem_width are driven from the granted port; mem_we=0 for fetch; mem_width=10 for fetch.
REQ-030 Outside a grant cycle: mem_en=0 and mem_we=0; mem_addr, mem_wdata and mem_width hold their last values.
REQ-031 Fetch or load grant: the 3-bit latency counter loads LATENCY and decrements each cycle in the BUSY state.
REQ-032 Read completion occurs at cycle T+LATENCY: the matching if_rvalid or d_done pulses for one cycle and the rdata output equals mem_rdata that cycle.
REQ-033 Store grant: d_done pulses at T+1; d_rdata is unchanged.
REQ-034 The FSM returns to IDLE on the cycle after the completion pulse; the earliest next grant is completion+1.
REQ-035 if_rdata and d_rdata are registered and hold until the next completion on their own port.
REQ-036 Streak counter (4 bits): increments on a d_gnt when if_req=1; clears on if_gnt or on a d_gnt when if_req=0; saturates at MAX_D_STREAK.
REQ-037 Requests arriving while busy are ignored until IDLE; requesters must hold req and operands stable until granted.
REQ-038 A deasserted request before grant is legal; no grant is issued and no state changes.
REQ-039 mem_rdata is ignored in every cycle other than read completion cycles.

Reset
REQ-040 On rst=1 at a clock edge: state=IDLE, latency counter=0, streak=0, if_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0, mem_width=0.
REQ-041 While rst=1, all grants, pulses, mem_en, mem_we and busy are 0.
REQ-042 Reset during an outstanding transaction drops the transaction: no completion pulse is issued after reset deasserts.

Verification
REQ-043 LATENCY=1, if_req only, if_addr=0x200, mem_rdata=0x00000013 -> if_gnt at T, if_rvalid with if_rdata=0x13 at T+1, busy=0 at T+2.
REQ-044 if_req and d_req both high, d_we=0, d_addr=0x1000 -> d_gnt first, mem_addr=0x1000; if_gnt at the first IDLE cycle after d_done.
REQ-045 Store d_addr=0x40, d_wdata=0xDEADBEEF, d_width=00 -> mem_we=1 and mem_width=00 at T; d_done at T+1; next grant no earlier than T+2.
REQ-046 MAX_D_STREAK=2, d_req and if_req held high continuously -> grant sequence D, D, IF, D, D, IF.
REQ-047 LATENCY=3, rst pulsed at T+1 after a fetch grant -> no if_rvalid occurs, busy=0, outputs at reset values, new grant possible the cycle after rst falls.
